bfly_pipe_param: RTL and testbench

- Fully pipelined, parametrised Kyber-family butterfly unit for the NTT datapath.
- Supports three modes: Cooley-Tukey forward butterfly, Gentleman-Sande inverse butterfly with exact modular halving, and bypass.
- Mode, tag and range-error flag travel with each sample, so modes may change every cycle without corrupting in-flight data.
- Has a global clock-enable stall for backpressure from the memory/address controller; sits between the coefficient RAM read ports and write-back.

---
 rtl/bfly_if.sv | 28 ++
 rtl/bfly_pipe_param.sv | 140 ++++++++++++++
 tb/tb_bfly_pipe_param.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bfly_if.sv
// Butterfly sample bus: one operand pair and its twiddle go in, one result pair comes out.
// in_valid qualifies a sample only on an edge where en=1; there is no ready, so a stalled bus simply holds.
interface bfly_if #(
  parameter int W     = 16,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic [1:0]       mode;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     w;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [W-1:0]     c;
  logic [W-1:0]     d;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, mode, a, b, w, in_tag,
    input  out_valid, c, d, out_tag, out_err
  );

  modport slave (
    input  in_valid, mode, a, b, w, in_tag,
    output out_valid, c, d, out_tag, out_err
  );
endinterface

// File: rtl/bfly_pipe_param.sv
// Six-register CT / GS / bypass butterfly with Montgomery twiddle multiply.
// Mode, tag and error flag ride alongside each sample; en freezes the whole pipe.
module bfly_pipe_param #(
  parameter int W     = 16,
  parameter int Q     = 3329,
  parameter int QINV  = 3327,
  parameter int TAG_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  bfly_if.slave  io
);
  localparam logic [1:0]   MODE_GS   = 2'b01;
  localparam logic [1:0]   MODE_BYP  = 2'b10;
  localparam logic [1:0]   MODE_IDLE = 2'b11;
  localparam logic [1:0]   MODE_CT   = 2'b00;
  localparam logic [W:0]   QX        = (W+1)'(Q);
  localparam logic [W-1:0] QW        = W'(Q);
  localparam logic [W-1:0] QINV_W    = W'(QINV);

  typedef struct packed {
    logic             v;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     sum;
  } side_t;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + QX - {1'b0, y};
    return s[W-1:0];
  endfunction

  // Exact division by two in Z_Q: odd values borrow one Q to become even.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return s[W:1];
  endfunction

  // (prod + m*Q) / R is below 2Q because prod < Q*Q < Q*R; one subtract makes it canonical.
  function automatic logic [W-1:0] mont_fin(input logic [2*W-1:0] prod, input logic [W-1:0] m);
    logic [2*W-1:0] mq;
    logic [2*W:0]   s;
    logic [W:0]     t;
    mq = (2*W)'(m) * (2*W)'(QW);
    s  = {1'b0, prod} + {1'b0, mq};
    t  = s[2*W:W];
    if (t >= QX) t = t - QX;
    return t[W-1:0];
  endfunction

  side_t          s0, s1, s2, s3, s4;
  side_t          in_side, s1_d;
  logic [W-1:0]   w0, w1, op1;
  logic [2*W-1:0] prod2, prod3;
  logic [W-1:0]   m3, t4;
  logic           out_valid_r, err_r;
  logic [W-1:0]   c_r, d_r, c_d, d_d;
  logic [TAG_W-1:0] tag_r;

  always_comb begin
    in_side      = '0;
    in_side.v    = io.in_valid && (io.mode != MODE_IDLE);
    in_side.mode = io.mode;
    in_side.tag  = io.in_tag;
    in_side.err  = (io.a >= QW) || (io.b >= QW) || ((io.mode != MODE_BYP) && (io.w >= QW));
    in_side.a    = io.a;
    in_side.b    = io.b;
    s1_d         = s0;
    s1_d.sum     = mod_add(s0.a, s0.b);
  end

  always_comb begin
    c_d = s4.a;
    d_d = s4.b;
    case (s4.mode)
      MODE_CT: begin
        c_d = mod_add(s4.a, t4);
        d_d = mod_sub(s4.a, t4);
      end
      MODE_GS: begin
        c_d = half_mod(s4.sum);
        d_d = half_mod(t4);
      end
      default: begin
        c_d = s4.a;
        d_d = s4.b;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0; s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
      w0 <= '0; w1 <= '0; op1 <= '0;
      prod2 <= '0; prod3 <= '0; m3 <= '0; t4 <= '0;
      out_valid_r <= 1'b0; c_r <= '0; d_r <= '0; tag_r <= '0; err_r <= 1'b0;
    end else if (en) begin
      s0    <= in_side;
      w0    <= io.w;
      s1    <= s1_d;
      w1    <= w0;
      // GS multiplies the difference, CT multiplies b directly.
      op1   <= (s0.mode == MODE_GS) ? mod_sub(s0.b, s0.a) : s0.b;
      s2    <= s1;
      prod2 <= (2*W)'(op1) * (2*W)'(w1);
      s3    <= s2;
      prod3 <= prod2;
      m3    <= prod2[W-1:0] * QINV_W;
      s4    <= s3;
      t4    <= mont_fin(prod3, m3);
      out_valid_r <= s4.v;
      if (s4.v) begin
        c_r   <= c_d;
        d_r   <= d_d;
        tag_r <= s4.tag;
        err_r <= s4.err;
      end
    end
  end

  assign io.out_valid = out_valid_r;
  assign io.c         = c_r;
  assign io.d         = d_r;
  assign io.out_tag   = tag_r;
  assign io.out_err   = err_r;
endmodule

// File: tb/tb_bfly_pipe_param.sv
// Bench for bfly_pipe_param: directed vectors plus a random stream, checked every cycle
// against a modular-arithmetic model with a five-enabled-edge delay queue.
module tb_bfly_pipe_param;
  localparam int W    = 16;
  localparam int Q    = 3329;
  localparam int RINV = 169;
  localparam int TW   = 8;

  typedef struct {
    int   due;
    int   c;
    int   d;
    int   tag;
    logic err;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   tests = 0;
  int   fails = 0;

  bfly_if #(.W(W), .TAG_W(TW)) io ();

  bfly_pipe_param #(.W(W), .Q(Q), .QINV(3327), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .io    (io)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int half(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  function automatic int mont(input longint x);
    return int'((x * RINV) % Q);
  endfunction

  function automatic rec_t model(input int a, input int b, input int w, input int m, input int tag);
    rec_t r;
    int   t;
    r.due = 0;
    r.tag = tag;
    r.err = (a >= Q) || (b >= Q) || ((m != 2) && (w >= Q));
    case (m)
      0: begin
        t   = mont(longint'(b) * w);
        r.c = (a + t) % Q;
        r.d = (a - t + Q) % Q;
      end
      1: begin
        r.c = half((a + b) % Q);
        r.d = half(mont(longint'((b - a + Q) % Q) * w));
      end
      default: begin
        r.c = a;
        r.d = b;
      end
    endcase
    return r;
  endfunction

  // scoreboard
  rec_t exp_q[$];
  int   en_cnt = 0;
  int   dut_out_cnt = 0;
  logic exp_valid = 1'b0;
  int   exp_c = 0, exp_d = 0, exp_tag = 0;
  logic exp_err = 1'b0;
  logic cd_known = 1'b1;

  always @(negedge rst_n) begin
    exp_q.delete();
    exp_valid = 1'b0;
    exp_c = 0; exp_d = 0; exp_tag = 0; exp_err = 1'b0;
    cd_known = 1'b1;
  end

  always @(posedge clk) begin
    logic s_en, s_v;
    int   s_mode, s_a, s_b, s_w, s_tag;
    rec_t r;
    if (!rst_n) begin
      #1;
      chk("rst_valid", 32'(io.out_valid), 0);
      chk("rst_c", 32'(io.c), 0);
      chk("rst_d", 32'(io.d), 0);
      chk("rst_tag", 32'(io.out_tag), 0);
      chk("rst_err", 32'(io.out_err), 0);
    end else begin
      s_en = en; s_v = io.in_valid; s_mode = int'(io.mode);
      s_a = int'(io.a); s_b = int'(io.b); s_w = int'(io.w); s_tag = int'(io.in_tag);
      if (s_en) begin
        en_cnt++;
        if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
          r = exp_q.pop_front();
          exp_valid = 1'b1;
          exp_tag = r.tag;
          exp_err = r.err;
          exp_c = r.c;
          exp_d = r.d;
          cd_known = !r.err;
        end else begin
          exp_valid = 1'b0;
        end
        if (s_v && s_mode != 3) begin
          r = model(s_a, s_b, s_w, s_mode, s_tag);
          r.due = en_cnt + 5;
          exp_q.push_back(r);
        end
      end
      #1;
      if (s_en && io.out_valid === 1'b1) dut_out_cnt++;
      chk("out_valid", 32'(io.out_valid), 32'(exp_valid));
      chk("out_tag", 32'(io.out_tag), 32'(exp_tag));
      chk("out_err", 32'(io.out_err), 32'(exp_err));
      if (cd_known) begin
        chk("out_c", 32'(io.c), 32'(exp_c));
        chk("out_d", 32'(io.d), 32'(exp_d));
      end
    end
  end

  // driver
  task automatic drive(input logic e, input logic v, input int m, input int av, input int bv,
                       input int wv, input int tg);
    @(negedge clk);
    en          = e;
    io.in_valid = v;
    io.mode     = 2'(m);
    io.a        = 16'(av);
    io.b        = 16'(bv);
    io.w        = 16'(wv);
    io.in_tag   = 8'(tg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 3, 0, 0, 0, 0);
  endtask

  initial begin
    rec_t p;
    int   n0;
    rst_n = 1'b0; en = 1'b0;
    io.in_valid = 1'b0; io.mode = 2'b11; io.a = '0; io.b = '0; io.w = '0; io.in_tag = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // hand-computed pins on the model
    p = model(100, 1, 2285, 0, 5);
    chk("pin_ct_c", 32'(p.c), 101); chk("pin_ct_d", 32'(p.d), 99);
    p = model(3328, 2, 2285, 0, 6);
    chk("pin_wrap_c", 32'(p.c), 1); chk("pin_wrap_d", 32'(p.d), 3326);
    p = model(0, 5, 2285, 0, 7);
    chk("pin_wrap2_c", 32'(p.c), 5); chk("pin_wrap2_d", 32'(p.d), 3324);
    p = model(1, 4, 2285, 1, 8);
    chk("pin_gs_c", 32'(p.c), 1667); chk("pin_gs_d", 32'(p.d), 1666);
    chk("pin_gs_2c", 32'((2 * p.c) % Q), 5); chk("pin_gs_2d", 32'((2 * p.d) % Q), 3);
    p = model(3328, 17, 0, 2, 12);
    chk("pin_byp_c", 32'(p.c), 3328); chk("pin_byp_d", 32'(p.d), 17);
    p = model(3329, 0, 2285, 0, 20);
    chk("pin_err", 32'(p.err), 1);

    // CT basic, CT wrap, GS halving
    drive(1'b1, 1'b1, 0, 100, 1, 2285, 5);
    idle(7);
    drive(1'b1, 1'b1, 0, 3328, 2, 2285, 6);
    drive(1'b1, 1'b1, 0, 0, 5, 2285, 7);
    idle(7);
    drive(1'b1, 1'b1, 1, 1, 4, 2285, 8);
    idle(7);

    // mixed stream with a 3-cycle stall
    n0 = dut_out_cnt;
    drive(1'b1, 1'b1, 0, 50, 60, 17, 10);
    drive(1'b1, 1'b1, 1, 200, 3000, 1234, 11);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 0, 9, 9, 9, 99);
    drive(1'b1, 1'b1, 2, 3328, 17, 0, 12);
    drive(1'b1, 1'b1, 3, 1, 2, 3, 13);
    idle(10);
    chk("mixed_count", 32'(dut_out_cnt - n0), 3);

    // range error then legal sample
    drive(1'b1, 1'b1, 0, 3329, 0, 2285, 20);
    drive(1'b1, 1'b1, 0, 7, 8, 2285, 21);
    idle(7);

    // reset with samples in flight
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i % 3, 10 + i, 20 + i, 300 + i, 30 + i);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(io.out_valid), 0);
    chk("async_rst_c", 32'(io.c), 0);
    chk("async_rst_d", 32'(io.d), 0);
    chk("async_rst_tag", 32'(io.out_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    io.in_valid = 1'b0;
    idle(8);
    drive(1'b1, 1'b1, 0, 100, 1, 2285, 40);
    idle(7);

    // random canonical stream with random stalls
    for (int i = 0; i < 10000; i++)
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
            int'($urandom_range(0, Q - 1)), int'($urandom_range(0, 255)));
    idle(10);
    chk("queue_drained", 32'(exp_q.size()), 0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
